elevator_controller: RTL



---
 rtl/elevator_pkg.sv | 19 +
 rtl/elevator_timer.sv | 45 ++++
 rtl/elevator_controller.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/elevator_pkg.sv
// Shared state encoding and default sizing for the elevator car controller.
package elevator_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVE_UP   = 2'd1,
        MOVE_DOWN = 2'd2,
        DOOR_OPEN = 2'd3
    } state_e;

    localparam int N_FLOORS_DEF      = 4;
    localparam int FLOOR_W_DEF       = 2;
    localparam int TRAVEL_CYCLES_DEF = 8;
    localparam int DOOR_CYCLES_DEF   = 16;

    // Interval counter width; covers both travel and door intervals.
    localparam int CNT_W = 8;

endpackage

// File: rtl/elevator_timer.sv
// Interval counter shared by floor travel and door hold times.
module elevator_timer
    import elevator_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             restart,
    input  logic [CNT_W-1:0] limit,
    output logic             done
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             run_q;
    logic             run_d;

    assign done = run_q && (count_q == limit);

    // done stops the counter unless the owner reloads it on the same edge
    always_comb begin
        count_d = count_q;
        run_d   = run_q;
        if (start || restart) begin
            count_d = '0;
            run_d   = 1'b1;
        end else if (done) begin
            count_d = '0;
            run_d   = 1'b0;
        end else if (run_q) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
            run_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            run_q   <= run_d;
        end
    end

endmodule

// File: rtl/elevator_controller.sv
// SCAN car-motion controller: moves floor by floor, opens the door at
// requested floors and pulses clr back to the served request cell.
module elevator_controller
    import elevator_pkg::*;
#(
    parameter int N_FLOORS      = N_FLOORS_DEF,
    parameter int FLOOR_W       = FLOOR_W_DEF,
    parameter int TRAVEL_CYCLES = TRAVEL_CYCLES_DEF,
    parameter int DOOR_CYCLES   = DOOR_CYCLES_DEF
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [N_FLOORS-1:0] req,
    output logic [N_FLOORS-1:0] clr,
    output logic [FLOOR_W-1:0]  floor,
    output logic                moving_up,
    output logic                moving_down,
    output logic                door_open,
    output logic                dir_up
);

    localparam logic [N_FLOORS-1:0] ONE        = N_FLOORS'(1);
    localparam logic [FLOOR_W-1:0]  TOP        = FLOOR_W'(N_FLOORS - 1);
    localparam logic [CNT_W-1:0]    TRAVEL_LIM = CNT_W'(TRAVEL_CYCLES - 1);
    localparam logic [CNT_W-1:0]    DOOR_LIM   = CNT_W'(DOOR_CYCLES - 1);

    state_e              state_q;
    state_e              state_d;
    logic [FLOOR_W-1:0]  floor_q;
    logic [FLOOR_W-1:0]  floor_d;
    logic                dir_up_q;
    logic                dir_up_d;
    logic [N_FLOORS-1:0] clr_q;
    logic [N_FLOORS-1:0] clr_d;
    logic                moving_up_q;
    logic                moving_up_d;
    logic                moving_down_q;
    logic                moving_down_d;
    logic                door_open_q;
    logic                door_open_d;

    logic [FLOOR_W-1:0]  nf;
    logic                here;
    logic                above;
    logic                below;
    logic                here_n;
    logic                above_n;
    logic                below_n;
    logic                go_up;
    logic                go_down;

    logic                tmr_start;
    logic                tmr_restart;
    logic                tmr_done;
    logic [CNT_W-1:0]    tmr_limit;

    // nf is the floor the car reaches when the current step completes
    always_comb begin
        nf = floor_q;
        if (state_q == MOVE_UP && floor_q != TOP) begin
            nf = floor_q + 1'b1;
        end else if (state_q == MOVE_DOWN && floor_q != '0) begin
            nf = floor_q - 1'b1;
        end
        here    = req[floor_q];
        here_n  = req[nf];
        above   = 1'b0;
        below   = 1'b0;
        above_n = 1'b0;
        below_n = 1'b0;
        for (int i = 0; i < N_FLOORS; i++) begin
            if (FLOOR_W'(i) > floor_q) above   = above   | req[i];
            if (FLOOR_W'(i) < floor_q) below   = below   | req[i];
            if (FLOOR_W'(i) > nf)      above_n = above_n | req[i];
            if (FLOOR_W'(i) < nf)      below_n = below_n | req[i];
        end
    end

    // Keep the current direction while it still has work.
    assign go_up   = above && (dir_up_q || !below);
    assign go_down = below && !go_up;

    assign tmr_limit = (state_q == DOOR_OPEN) ? DOOR_LIM : TRAVEL_LIM;

    elevator_timer u_timer (
        .clock   (clock),
        .reset   (reset),
        .start   (tmr_start),
        .restart (tmr_restart),
        .limit   (tmr_limit),
        .done    (tmr_done)
    );

    always_comb begin
        state_d     = state_q;
        floor_d     = floor_q;
        dir_up_d    = dir_up_q;
        clr_d       = '0;
        tmr_start   = 1'b0;
        tmr_restart = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (here) begin
                    state_d   = DOOR_OPEN;
                    clr_d     = ONE << floor_q;
                    tmr_start = 1'b1;
                end else if (go_up) begin
                    state_d   = MOVE_UP;
                    dir_up_d  = 1'b1;
                    tmr_start = 1'b1;
                end else if (go_down) begin
                    state_d   = MOVE_DOWN;
                    dir_up_d  = 1'b0;
                    tmr_start = 1'b1;
                end
            end
            MOVE_UP, MOVE_DOWN: begin
                if (tmr_done) begin
                    floor_d = nf;
                    if (here_n) begin
                        state_d   = DOOR_OPEN;
                        clr_d     = ONE << nf;
                        tmr_start = 1'b1;
                    end else if ((state_q == MOVE_UP) ? above_n : below_n) begin
                        tmr_start = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DOOR_OPEN: begin
                // clr_q high means req[floor] is still the old request
                if (here && clr_q == '0) begin
                    tmr_restart = 1'b1;
                    clr_d       = ONE << floor_q;
                end else if (tmr_done) begin
                    if (go_up) begin
                        state_d   = MOVE_UP;
                        dir_up_d  = 1'b1;
                        tmr_start = 1'b1;
                    end else if (go_down) begin
                        state_d   = MOVE_DOWN;
                        dir_up_d  = 1'b0;
                        tmr_start = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
        endcase
        moving_up_d   = (state_d == MOVE_UP);
        moving_down_d = (state_d == MOVE_DOWN);
        door_open_d   = (state_d == DOOR_OPEN);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            floor_q       <= '0;
            dir_up_q      <= 1'b1;
            clr_q         <= '0;
            moving_up_q   <= 1'b0;
            moving_down_q <= 1'b0;
            door_open_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            floor_q       <= floor_d;
            dir_up_q      <= dir_up_d;
            clr_q         <= clr_d;
            moving_up_q   <= moving_up_d;
            moving_down_q <= moving_down_d;
            door_open_q   <= door_open_d;
        end
    end

    assign clr         = clr_q;
    assign floor       = floor_q;
    assign moving_up   = moving_up_q;
    assign moving_down = moving_down_q;
    assign door_open   = door_open_q;
    assign dir_up      = dir_up_q;

endmodule
